// File: rtl/shift_sequencer.sv
// shift_sequencer: step/direction controller for a 4-bit one-hot shifter.
// Generates a step strobe every TICK_DIV cycles with a direction flag, keeps a
// cycle-accurate mirror of the shifter pattern, and counts completed passes
// for LEFT, RIGHT and BOUNCE scrolling.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   run request, accepted only in IDLE with a non-zero mode
//   stop     in   abort request, priority over start
//   mode     in   00 none, 01 left, 10 right, 11 bounce (latched on start)
//   passes   in   passes before done, 0 = forever (latched on start)
//   step     out  one-cycle shift enable
//   flag     out  direction for the current step, 1 = left
//   pos      out  mirror of the shifter pattern
//   busy     out  high while running
//   done     out  one-cycle pulse when the programmed passes complete
//   pass_cnt out  passes completed in the current run (wraps mod 16)
module shift_sequencer #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [3:0] passes,
  output logic       step,
  output logic       flag,
  output logic [3:0] pos,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] ModeNone   = 2'd0;
  localparam logic [1:0] ModeLeft   = 2'd1;
  localparam logic [1:0] ModeRight  = 2'd2;
  localparam logic [1:0] ModeBounce = 2'd3;

  localparam logic [23:0] TickLast = 24'(TICK_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  pass_cnt_q, pass_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  passes_q, passes_d;
  logic        dir_q, dir_d;  // bounce travel direction, 1 = left

  logic       in_run;
  logic       step_now;
  logic       flag_c;
  logic [3:0] pos_shift;
  logic       is_pass;
  logic [3:0] cnt_inc;

  always_comb begin
    in_run   = (state_q == StRun);
    step_now = in_run && !stop && (presc_q == TickLast);

    flag_c = 1'b0;
    if (in_run) begin
      case (mode_q)
        ModeLeft:  flag_c = 1'b1;
        ModeRight: flag_c = 1'b0;
        ModeBounce: begin
          // Reverse at either end so the pattern never falls off to 0000.
          if (pos_q == 4'b1000 && dir_q)       flag_c = 1'b0;
          else if (pos_q == 4'b0001 && !dir_q) flag_c = 1'b1;
          else                                 flag_c = dir_q;
        end
        default:   flag_c = 1'b0;
      endcase
    end

    // Shifter rule: an empty register injects a one at the entry end.
    if (pos_q == 4'b0000) pos_shift = flag_c ? 4'b0001 : 4'b1000;
    else                  pos_shift = flag_c ? {pos_q[2:0], 1'b0} : {1'b0, pos_q[3:1]};

    case (mode_q)
      ModeLeft:   is_pass = (pos_q == 4'b1000);
      ModeRight:  is_pass = (pos_q == 4'b0001);
      ModeBounce: is_pass = (pos_q == 4'b0010) && !flag_c;
      default:    is_pass = 1'b0;
    endcase
    cnt_inc = pass_cnt_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    pos_d      = pos_q;
    pass_cnt_d = pass_cnt_q;
    mode_d     = mode_q;
    passes_d   = passes_q;
    dir_d      = dir_q;

    case (state_q)
      StIdle: begin
        if (start && !stop && mode != ModeNone) begin
          state_d    = StRun;
          presc_d    = '0;
          pos_d      = 4'b0000;
          pass_cnt_d = '0;
          mode_d     = mode;
          passes_d   = passes;
          dir_d      = (mode != ModeRight);
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          pos_d   = 4'b0000;
          presc_d = '0;
        end else if (step_now) begin
          presc_d = '0;
          pos_d   = pos_shift;
          dir_d   = flag_c;
          if (is_pass) begin
            pass_cnt_d = cnt_inc;
            if (passes_q != 4'd0 && cnt_inc == passes_q) state_d = StDone;
          end
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        pos_d   = 4'b0000;
        presc_d = '0;
      end
      default: begin
        state_d = StIdle;
        pos_d   = 4'b0000;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      pos_q      <= '0;
      pass_cnt_q <= '0;
      mode_q     <= ModeNone;
      passes_q   <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pos_q      <= pos_d;
      pass_cnt_q <= pass_cnt_d;
      mode_q     <= mode_d;
      passes_q   <= passes_d;
      dir_q      <= dir_d;
    end
  end

  assign step     = step_now;
  assign flag     = flag_c;
  assign pos      = pos_q;
  assign busy     = in_run;
  assign done     = (state_q == StDone);
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer with TICK_DIV=4: directed scenarios followed by
// randomized runs, all checked each cycle against a behavioural model that
// tracks the lit LED as an index (-1 = all dark).
module tb_shift_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [3:0] passes;
  logic       step, flag, busy, done;
  logic [3:0] pos, pass_cnt;

  shift_sequencer #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .passes   (passes),
    .step     (step),
    .flag     (flag),
    .pos      (pos),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = -1;
  int done_total = 0;

  // Model: ms 0 idle / 1 run / 2 done; mpos = lit bit index or -1.
  int ms, mcnt, mpos, mdir, mpc, mmode, mpasses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pos_vec(input int p);
    logic [3:0] v;
    v = 4'd0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  function automatic int model_flag();
    if (ms != 1) return 0;
    if (mmode == 1) return 1;
    if (mmode == 2) return 0;
    if (mpos == 3 && mdir == 1) return 0;
    if (mpos == 0 && mdir == 0) return 1;
    return mdir;
  endfunction

  task automatic model_reset();
    ms = 0; mcnt = 0; mpos = -1; mdir = 0; mpc = 0; mmode = 0; mpasses = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic tick();
    int  f, np;
    bit  e_step, passed;
    @(negedge clk);
    e_step = (ms == 1) && !stop && (mcnt == TD - 1);
    f = model_flag();
    check("busy", 32'(busy), 32'(ms == 1));
    check("done", 32'(done), 32'(ms == 2));
    check("pos", 32'(pos), 32'(pos_vec(mpos)));
    check("pass_cnt", 32'(pass_cnt), 32'(mpc));
    check("step", 32'(step), 32'(e_step));
    if (e_step || ms == 0) check("flag", 32'(flag), 32'(f));
    if (done === 1'b1) begin
      done_total++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (rst) begin
      model_reset();
    end else if (ms == 0) begin
      if (start && !stop && mode != 2'd0) begin
        ms = 1; mcnt = 0; mpos = -1; mpc = 0;
        mmode = int'(mode); mpasses = int'(passes); mdir = (mode != 2'd2) ? 1 : 0;
      end
    end else if (ms == 2) begin
      ms = 0; mpos = -1;
    end else if (stop) begin
      ms = 0; mpos = -1;
    end else if (e_step) begin
      mcnt = 0;
      passed = (mmode == 1 && mpos == 3) || (mmode == 2 && mpos == 0) ||
               (mmode == 3 && mpos == 1 && f == 0);
      if (mpos < 0) np = (f != 0) ? 0 : 3;
      else          np = mpos + ((f != 0) ? 1 : -1);
      mpos = (np < 0 || np > 3) ? -1 : np;
      mdir = f;
      if (passed) begin
        mpc = (mpc + 1) % 16;
        if (mpasses != 0 && mpc == mpasses) ms = 2;
      end
    end else begin
      mcnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start in cycle 0 and run to idle; check the cycle in which done appears.
  task automatic do_run(input logic [1:0] m, input logic [3:0] p, input int exp_done,
                        input string tag);
    int guard;
    mode = m; passes = p; start = 1'b1; cyc = 0; done_cyc = -1;
    tick();
    start = 1'b0;
    guard = 0;
    while (ms != 0 && guard < 2000) begin
      tick();
      guard++;
    end
    check({tag, "_timeout"}, 32'(guard < 2000), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    int guard, stop_at, done_before;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; passes = 4'd0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();
    check("reset_pos", 32'(pos), 32'd0);

    do_run(2'd1, 4'd1, 21, "left_p1");
    check("left_p1_cnt", 32'(pass_cnt), 32'd1);
    do_run(2'd2, 4'd2, 41, "right_p2");
    check("right_p2_cnt", 32'(pass_cnt), 32'd2);
    do_run(2'd3, 4'd1, 29, "bounce_p1");

    // Endless LEFT: 80 steps = 16 passes, so the counter wraps to 0.
    done_before = done_total;
    mode = 2'd1; passes = 4'd0; start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    while (cyc < 322) begin
      tick();
      if (cyc == 162) check("forever_cnt_mid", 32'(pass_cnt), 32'd8);
    end
    check("forever_cnt_wrap", 32'(pass_cnt), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("forever_stop_busy", 32'(busy), 32'd0);
    check("forever_no_done", 32'(done_total), 32'(done_before));

    // Ignored starts.
    mode = 2'd1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("start_stop_busy", 32'(busy), 32'd0);
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mode0_busy", 32'(busy), 32'd0);

    // Reset right after the 2nd step.
    done_before = done_total;
    mode = 2'd1; passes = 4'd3; start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    while (cyc < 9) tick();
    check("pre_rst_pos", 32'(pos), 32'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_no_done", 32'(done_total), 32'(done_before));
    do_run(2'd1, 4'd1, 21, "after_rst");

    // Randomized runs with noisy inputs while running and occasional stops.
    for (int r = 0; r < 10; r++) begin
      stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 60)) : -1;
      mode = 2'($urandom_range(1, 3));
      passes = 4'($urandom_range(0, 3));
      if (stop_at < 0 && passes == 4'd0) passes = 4'd1;
      start = 1'b1; cyc = 0;
      tick();
      guard = 0;
      while (ms != 0 && guard < 1000) begin
        start = 1'($urandom);
        mode = 2'($urandom);
        passes = 4'($urandom);
        stop = (cyc == stop_at);
        tick();
        guard++;
      end
      start = 1'b0; stop = 1'b0;
      check("rand_timeout", 32'(guard < 1000), 32'd1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
